// File: rtl/fx3_slave_fifo_emu_pkg.sv
// Shared constants, types and strobe decoding for the FX3 slave-FIFO emulator.
// Package name is fx3_emu_pkg; imported by the FIFO, interface users and the top.
package fx3_emu_pkg;

    localparam logic [1:0] OUT_ADDR_DEF = 2'b00;
    localparam logic [1:0] IN_ADDR_DEF  = 2'b11;

    localparam int ERR_IN_OVF   = 0;
    localparam int ERR_OUT_UNF  = 1;
    localparam int ERR_BAD_ADDR = 2;
    localparam int ERR_RDWR     = 3;

    localparam int RD_LATENCY = 2;

    typedef logic [7:0] byte_t;

    typedef struct packed {
        logic rd;    // valid pop from the OUT socket
        logic wr;    // valid push into the IN socket
        logic both;  // read and write strobes together
        logic bad;   // single strobe aimed at the wrong socket
    } strobe_t;

    function automatic strobe_t decode_strobe(input logic cs_n, input logic rd_n,
                                              input logic wr_n, input logic [1:0] a,
                                              input logic [1:0] out_a, input logic [1:0] in_a);
        strobe_t s;
        logic    rd;
        logic    wr;
        rd     = ~cs_n & ~rd_n;
        wr     = ~cs_n & ~wr_n;
        s.both = rd & wr;
        s.rd   = rd & ~wr & (a == out_a);
        s.wr   = wr & ~rd & (a == in_a);
        s.bad  = (rd & ~wr & (a != out_a)) | (wr & ~rd & (a != in_a));
        return s;
    endfunction

endpackage

// File: rtl/fx3_slave_fifo_emu_if.sv
// GPIF II slave-FIFO bus between the FX3 master and the emulated FPGA slave.
interface fx3_slave_fifo_emu_if;

    logic       fx3_slcs_n;
    logic       fx3_slrd_n;
    logic       fx3_slwr_n;
    logic       fx3_sloe_n;
    logic [1:0] fx3_a;
    logic [7:0] fx3_din;
    logic [7:0] fx3_dout;
    logic       fx3_doe;
    logic       fx3_flaga;

    modport master (
        output fx3_slcs_n, fx3_slrd_n, fx3_slwr_n, fx3_sloe_n, fx3_a, fx3_din,
        input  fx3_dout, fx3_doe, fx3_flaga
    );

    modport slave (
        input  fx3_slcs_n, fx3_slrd_n, fx3_slwr_n, fx3_sloe_n, fx3_a, fx3_din,
        output fx3_dout, fx3_doe, fx3_flaga
    );

endinterface

// File: rtl/fx3_slave_fifo_emu_fifo.sv
// Circular byte buffer with occupancy count; push while full is dropped unless
// a pop happens in the same cycle, pop while empty is ignored.
module fx3_emu_fifo
    import fx3_emu_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  byte_t                  push_data,
    input  logic                   pop,
    output byte_t                  rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   pop_ok
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    byte_t           mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push_ok;

    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & (count != '0);
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

    // Pointer width equals log2(DEPTH), so increments wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fx3_slave_fifo_emu.sv
// FX3 slave-FIFO emulator: OUT socket preloaded by the host and read by the
// GPIF master through a 2-stage pipeline; IN socket written by the master and drained by the host.
module fx3_slave_fifo_emu
    import fx3_emu_pkg::*;
#(
    parameter int         DEPTH     = 1024,
    parameter int         WATERMARK = 4,
    parameter logic [1:0] OUT_ADDR  = OUT_ADDR_DEF,
    parameter logic [1:0] IN_ADDR   = IN_ADDR_DEF
) (
    input  logic                   fx3_clk,
    input  logic                   fx3_rst_n,
    fx3_slave_fifo_emu_if.slave    gpif,
    input  logic                   host_wr_en,
    input  byte_t                  host_wr_data,
    output logic                   host_full,
    input  logic                   host_rd_en,
    output byte_t                  host_rd_data,
    output logic                   host_rd_vld,
    output logic                   host_empty,
    output logic [$clog2(DEPTH):0] out_count,
    output logic [$clog2(DEPTH):0] in_count,
    output logic [3:0]             err
);

    localparam int CW = $clog2(DEPTH) + 1;

    strobe_t stb;
    byte_t   out_rd_data;
    byte_t   in_rd_data;
    logic    out_full;
    logic    in_full;
    logic    out_pop_ok;
    logic    in_pop_ok;
    logic    flag_next;
    logic [3:0] err_set;

    logic [RD_LATENCY:1]       vld_pipe;
    byte_t [RD_LATENCY:1]      data_pipe;

    assign stb = decode_strobe(gpif.fx3_slcs_n, gpif.fx3_slrd_n, gpif.fx3_slwr_n,
                               gpif.fx3_a, OUT_ADDR, IN_ADDR);

    fx3_emu_fifo #(.DEPTH(DEPTH)) u_out_fifo (
        .clk       (fx3_clk),
        .rst_n     (fx3_rst_n),
        .push      (host_wr_en),
        .push_data (host_wr_data),
        .pop       (stb.rd),
        .rd_data   (out_rd_data),
        .count     (out_count),
        .full      (out_full),
        .pop_ok    (out_pop_ok)
    );

    fx3_emu_fifo #(.DEPTH(DEPTH)) u_in_fifo (
        .clk       (fx3_clk),
        .rst_n     (fx3_rst_n),
        .push      (stb.wr),
        .push_data (gpif.fx3_din),
        .pop       (host_rd_en),
        .rd_data   (in_rd_data),
        .count     (in_count),
        .full      (in_full),
        .pop_ok    (in_pop_ok)
    );

    assign host_full  = out_full;
    assign host_empty = (in_count == '0);

    // Stages only advance behind a valid byte, so dout holds the last read.
    always_ff @(posedge fx3_clk or negedge fx3_rst_n) begin
        if (!fx3_rst_n) begin
            vld_pipe  <= '0;
            data_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[RD_LATENCY-1:1], stb.rd};
            if (stb.rd) data_pipe[1] <= out_pop_ok ? out_rd_data : 8'h00;
            for (int k = 2; k <= RD_LATENCY; k++) begin
                if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
            end
        end
    end

    assign gpif.fx3_dout = data_pipe[RD_LATENCY];
    assign gpif.fx3_doe  = ~gpif.fx3_sloe_n & ~gpif.fx3_slcs_n;

    always_comb begin
        flag_next = 1'b0;
        if (gpif.fx3_a == OUT_ADDR)
            flag_next = (out_count >= CW'(WATERMARK));
        else if (gpif.fx3_a == IN_ADDR)
            flag_next = ((CW'(DEPTH) - in_count) >= CW'(WATERMARK));
    end

    always_comb begin
        err_set               = '0;
        err_set[ERR_IN_OVF]   = stb.wr & in_full & ~in_pop_ok;
        err_set[ERR_OUT_UNF]  = stb.rd & ~out_pop_ok;
        err_set[ERR_BAD_ADDR] = stb.bad;
        err_set[ERR_RDWR]     = stb.both;
    end

    always_ff @(posedge fx3_clk or negedge fx3_rst_n) begin
        if (!fx3_rst_n) begin
            gpif.fx3_flaga <= 1'b0;
            err            <= '0;
            host_rd_vld    <= 1'b0;
            host_rd_data   <= '0;
        end else begin
            gpif.fx3_flaga <= flag_next;
            err            <= err | err_set;
            host_rd_vld    <= in_pop_ok;
            if (in_pop_ok) host_rd_data <= in_rd_data;
        end
    end

endmodule
